// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache with zero-latency hits and a ready/valid line fill.
// Optional ICACHE_PERF_COUNTERS_EN adds hit/miss counters.

module icache_line #(
  parameter int TAG_W      = 26,
  parameter int LINE_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [TAG_W-1:0]            wr_tag,
  input  logic [LINE_WORDS-1:0][31:0] wr_data,
  output logic                        vld,
  output logic [TAG_W-1:0]            tag,
  output logic [LINE_WORDS-1:0][31:0] data
);
  logic                        vld_q, vld_d;
  logic [TAG_W-1:0]            tag_q, tag_d;
  logic [LINE_WORDS-1:0][31:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (wr_en) begin
      vld_d  = 1'b1;
      tag_d  = wr_tag;
      data_d = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_q <= 1'b0;
    else        vld_q <= vld_d;
  end

  // Tag and data are only meaningful behind vld_q, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign vld  = vld_q;
  assign tag  = tag_q;
  assign data = data_q;
endmodule

module icache_responder #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_SETS   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      is_input_valid,
  input  logic [31:0]               addr,
  output logic                      is_ready,
  output logic                      is_output_valid,
  output logic [31:0]               dout,
  output logic                      is_hit,
  output logic                      is_not_cache_stall,
  input  logic                      mem_is_ready,
  output logic                      mem_read,
  output logic [31:0]               mem_addr,
  input  logic                      mem_output_valid,
`ifdef ICACHE_PERF_COUNTERS_EN
  input  logic [32*LINE_WORDS-1:0]  mem_dout,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
`else
  input  logic [32*LINE_WORDS-1:0]  mem_dout
`endif
);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFS_W  = WSEL_W + 2;
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - IDX_W - OFS_W;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] fill_addr_q, fill_addr_d;

  logic [NUM_SETS-1:0]                        set_vld;
  logic [NUM_SETS-1:0][TAG_W-1:0]             set_tag;
  logic [NUM_SETS-1:0][LINE_WORDS-1:0][31:0]  set_data;

  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic [WSEL_W-1:0] req_wsel;
  logic              lookup_hit;
  logic              fill_we;
  logic              hit_evt, miss_evt;
  logic              unused_addr_lo;

  assign req_idx        = addr[OFS_W+IDX_W-1:OFS_W];
  assign req_tag        = addr[31:OFS_W+IDX_W];
  assign req_wsel       = addr[OFS_W-1:2];
  assign unused_addr_lo = ^addr[1:0];
  assign fill_idx       = fill_addr_q[OFS_W+IDX_W-1:OFS_W];
  assign fill_tag       = fill_addr_q[31:OFS_W+IDX_W];
  assign lookup_hit     = set_vld[req_idx] && (set_tag[req_idx] == req_tag);
  assign mem_addr       = fill_addr_q;

  for (genvar i = 0; i < NUM_SETS; i++) begin : g_set
    icache_line #(.TAG_W(TAG_W), .LINE_WORDS(LINE_WORDS)) u_line (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (fill_we && (fill_idx == IDX_W'(i))),
      .wr_tag  (fill_tag),
      .wr_data (mem_dout),
      .vld     (set_vld[i]),
      .tag     (set_tag[i]),
      .data    (set_data[i])
    );
  end

  always_comb begin
    state_d            = state_q;
    fill_addr_d        = fill_addr_q;
    is_ready           = 1'b0;
    is_output_valid    = 1'b0;
    is_hit             = 1'b0;
    dout               = 32'h0;
    is_not_cache_stall = 1'b1;
    mem_read           = 1'b0;
    fill_we            = 1'b0;
    hit_evt            = 1'b0;
    miss_evt           = 1'b0;
    case (state_q)
      S_IDLE: begin
        is_ready = 1'b1;
        if (is_input_valid) begin
          if (lookup_hit) begin
            is_hit          = 1'b1;
            is_output_valid = 1'b1;
            dout            = set_data[req_idx][req_wsel];
            hit_evt         = 1'b1;
          end else begin
            // Stall in the detect cycle so the PC holds the missing address.
            is_not_cache_stall = 1'b0;
            fill_addr_d        = {addr[31:OFS_W], {OFS_W{1'b0}}};
            miss_evt           = 1'b1;
            state_d            = S_REQ;
          end
        end
      end
      S_REQ: begin
        is_not_cache_stall = 1'b0;
        mem_read           = 1'b1;
        if (mem_is_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        is_not_cache_stall = 1'b0;
        if (mem_output_valid) begin
          fill_we = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      fill_addr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
    end
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'h0, hit_evt};
    miss_cnt_d = miss_cnt_q + {31'h0, miss_evt};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = hit_evt ^ miss_evt;
`endif
endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped, read-only instruction cache that serves the fetch stage.
- It produces the is_not_cache_stall qualifier that gates the PC register's update.
- A fetch address is looked up combinationally. A hit returns the instruction in the same cycle. A miss blocks the front end while a full line is fetched from the multi-cycle instruction memory over a ready/valid handshake.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line; power of two, 2..8
- NUM_SETS, 16, number of lines; power of two
- Derived, not user parameters: OFS_W = log2(LINE_WORDS)+2, IDX_W = log2(NUM_SETS), TAG_W = 32-IDX_W-OFS_W

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- is_input_valid  in  1  fetch request present this cycle
- addr  in  32  fetch byte address; bits [1:0] ignored
- is_ready  out  1  cache can accept a lookup (state IDLE)
- is_output_valid  out  1  dout holds the requested instruction this cycle
- dout  out  32  instruction word
- is_hit  out  1  valid lookup hit this cycle
- is_not_cache_stall  out  1  0 while a fetch is outstanding and unserved
- mem_is_ready  in  1  memory can accept a request
- mem_read  out  1  line-fill request, held one cycle when accepted
- mem_addr  out  32  line-aligned fill address (offset bits zero)
- mem_output_valid  in  1  fill data valid, one-cycle pulse
- mem_dout  in  32*LINE_WORDS  fill line, word 0 in LSBs

Behaviour:
- Reset (reset==0, asynchronous):
  - all valid bits clear; state IDLE
  - outputs: mem_read=0, is_output_valid=0, is_hit=0, is_ready=1, is_not_cache_stall=1, dout=0
  - tag/data arrays need no reset.
- Address split: offset=addr[OFS_W-1:0], index=addr[OFS_W+IDX_W-1:OFS_W], tag=upper TAG_W bits.
- States: IDLE, REQ, WAIT.
- IDLE:
  - is_ready=1.
  - If is_input_valid and (valid[index] and tag match): is_hit=1, is_output_valid=1, dout=the word selected by addr[OFS_W-1:2], is_not_cache_stall=1. Zero-latency hit; state stays IDLE.
  - If is_input_valid and miss: is_not_cache_stall=0. Latch the line address into fill_addr; next state REQ.
  - If no request: is_not_cache_stall=1; outputs valid/hit=0.
- REQ:
  - is_ready=0, is_not_cache_stall=0, mem_read=1, mem_addr=fill_addr.
  - When mem_is_ready=1 at an edge, the request is accepted; next state WAIT.
  - Otherwise stay in REQ with mem_read held.
- WAIT:
  - mem_read=0, is_not_cache_stall=0.
  - On mem_output_valid: write mem_dout into data[fill index], write the tag, set valid; next state IDLE.
  - The CPU re-presents the same addr (the PC did not advance), so the next cycle hits.
- The fill writes the latched fill_addr, never the live addr. A changed addr during a miss does not corrupt the line.
- mem_output_valid in IDLE or REQ is ignored.
- is_not_cache_stall is combinational from state and lookup. It must be 0 in the same cycle a miss is detected, so the PC does not advance on a miss.
- Reset mid-fill: returns to IDLE with all valid bits clear. A later mem_output_valid for the aborted fill is ignored.
- Back-to-back hits sustain one instruction per cycle.
- Hit after fill: exactly one extra cycle after the mem_output_valid edge.

Optional Feature:
- Macro: ICACHE_PERF_COUNTERS_EN.
- Defined:
  - adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0
  - hit_count increments on each IDLE cycle with is_hit=1
  - miss_count increments on each IDLE-to-REQ transition
  - both counters wrap at 2^32
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, then one request with addr=0x00000040 -> is_hit=0, is_not_cache_stall=0; mem_read=1 with mem_addr=0x00000040. Memory returns the line {0x44,0x33,0x22,0x11} (word 0=0x11) -> the next cycle hits with dout=0x11 and is_not_cache_stall=1.
2. After test 1, requests at addr 0x44, 0x48, 0x4C on consecutive cycles -> three hits with dout 0x22, 0x33, 0x44; mem_read never asserted.
3. Conflict: addr=0x00000440 (same index, different tag, NUM_SETS=16, LINE_WORDS=4) -> miss and refill; a following request at 0x40 misses again.
4. Hold mem_is_ready=0 for 5 cycles in REQ -> mem_read stays 1 with mem_addr stable and is_not_cache_stall=0 throughout; the request is accepted on the first edge with mem_is_ready=1.
5. Assert reset low during WAIT, then pulse mem_output_valid after release -> state IDLE, no line installed; the next request at 0x40 misses.
6. With ICACHE_PERF_COUNTERS_EN defined, run tests 1 and 2 -> hit_count=4, miss_count=1.
